// File: rtl/ysyx_22041461_if_fetch_pkg.sv
// Shared definitions for the IF fetch responder: FSM encoding, beat geometry.
package ysyx_22041461_if_fetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam int MEM_WIDTH  = 64;

  // One memory beat carries two instructions, so requests drop pc[2:0].
  localparam logic [63:0] BEAT_MASK = ~64'h7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22041461_inst_sel.sv
// Picks the 32-bit instruction word out of a 64-bit memory beat.
module ysyx_22041461_inst_sel
  import ysyx_22041461_if_fetch_pkg::*;
#(
  parameter int MEM_W  = MEM_WIDTH,
  parameter int INST_W = INST_WIDTH
) (
  input  logic              hi,
  input  logic [MEM_W-1:0]  beat,
  output logic [INST_W-1:0] word
);

  assign word = hi ? beat[2*INST_W-1:INST_W] : beat[INST_W-1:0];

endmodule

// File: rtl/ysyx_22041461_if_fetch.sv
// IF stage fetch responder: one outstanding imem request, ID handoff, PC control.
module ysyx_22041461_if_fetch
  import ysyx_22041461_if_fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int MEM_W  = MEM_WIDTH,
  parameter int INST_W = INST_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  output logic              pc_enable,
  output logic              pc_sel,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [MEM_W-1:0]  imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc
);

  fetch_state_e      state, state_nxt;
  logic              kill, kill_nxt;
  logic [ADDR_W-1:0] pc_l, pc_l_nxt;
  logic              id_valid_nxt;
  logic [INST_W-1:0] id_inst_nxt;
  logic [ADDR_W-1:0] id_pc_nxt;
  logic [INST_W-1:0] rsp_word;
  logic              handoff;

  ysyx_22041461_inst_sel #(
    .MEM_W (MEM_W),
    .INST_W(INST_W)
  ) u_inst_sel (
    .hi  (pc_l[2]),
    .beat(imem_rsp_data),
    .word(rsp_word)
  );

  assign handoff        = id_valid & id_ready;
  // Redirect takes priority over the sequential pc+4 step.
  assign pc_sel         = redirect;
  assign pc_enable      = redirect | (handoff & ~redirect);
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc & BEAT_MASK[ADDR_W-1:0];

  always_comb begin
    state_nxt    = state;
    kill_nxt     = kill;
    pc_l_nxt     = pc_l;
    id_valid_nxt = id_valid;
    id_inst_nxt  = id_inst;
    id_pc_nxt    = id_pc;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // The request is never withdrawn; a redirect only poisons its response.
        if (redirect) kill_nxt = 1'b1;
        if (imem_req_ready) begin
          pc_l_nxt  = pc;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          kill_nxt  = 1'b0;
          state_nxt = IDLE;
          if (!kill && !redirect) begin
            id_inst_nxt  = rsp_word;
            id_pc_nxt    = pc_l;
            id_valid_nxt = 1'b1;
            state_nxt    = HOLD;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || handoff) begin
          id_valid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      kill     <= 1'b0;
      pc_l     <= '0;
      id_valid <= 1'b0;
      id_inst  <= '0;
      id_pc    <= '0;
    end else begin
      state    <= state_nxt;
      kill     <= kill_nxt;
      pc_l     <= pc_l_nxt;
      id_valid <= id_valid_nxt;
      id_inst  <= id_inst_nxt;
      id_pc    <= id_pc_nxt;
    end
  end

endmodule

// File: doc/ysyx_22041461_if_fetch.md
Name: ysyx_22041461_if_fetch

Overview:
Instruction-fetch responder for the IF stage: consumes the current PC from the PC register and fetches the instruction word from instruction memory via a valid/ready request plus response channel. It hands the instruction and its PC to ID with a valid/ready handshake. It drives the PC register's enable and select so the PC advances only after a handoff, or loads a redirect target. It also kills any in-flight fetch on redirect.

Parameters:
ADDR_W, 64, PC / memory address width
MEM_W, 64, instruction-memory data width (two instructions per beat)
INST_W, 32, instruction width

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-low reset
pc  input  ADDR_W  current PC from PC register
redirect  input  1  one-cycle pulse from EX: load redirect target into PC, flush fetch
pc_enable  output  1  PC register write enable
pc_sel  output  1  PC register select: 0 = pc+4, 1 = redirect target
imem_req_valid  output  1  memory request valid
imem_req_ready  input  1  memory request accepted
imem_req_addr  output  ADDR_W  beat-aligned address {pc[ADDR_W-1:3],3'b000}
imem_rsp_valid  input  1  response valid, one per accepted request, ≥1 cycle after accept
imem_rsp_data  input  MEM_W  response beat
id_valid  output  1  instruction valid to ID
id_ready  input  1  ID accepts
id_inst  output  INST_W  instruction
id_pc  output  ADDR_W  PC of id_inst

Behaviour:
- Reset (rst low, async): state IDLE. kill=0. pc_l=0. id_valid=0, id_inst=0, id_pc=0, imem_req_valid=0. Release is synchronised upstream.
- pc_enable = redirect | (id_valid & id_ready & ~redirect). pc_sel = redirect. Both are combinational and registered by the PC register on the same edge.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle for the PC register to settle. Next state is REQ.
- REQ: imem_req_valid=1, addr from the live pc. On imem_req_ready: pc_l<=pc, go to WAIT. Once asserted, valid is never withdrawn before ready.
- WAIT: on imem_rsp_valid:
  - kill=1: discard, clear kill, go to IDLE.
  - Otherwise: id_inst <= pc_l[2] ? data[63:32] : data[31:0]; id_pc <= pc_l; id_valid <= 1; go to HOLD.
- HOLD: id_valid and data are held stable until id_ready. On id_valid & id_ready: id_valid <= 0, go to IDLE.
- Minimum latency: PC stable to id_valid is 3 edges (REQ accepted same cycle, response next cycle). Back-to-back throughput is one instruction per 4 cycles.
- Redirect handling:
  - In IDLE: PC loads the target; proceed normally.
  - In REQ before accept: request still completes, kill <= 1.
  - In REQ with accept in the same cycle: kill <= 1.
  - In WAIT without rsp: kill <= 1.
  - In WAIT with rsp in the same cycle: response dropped, go to IDLE.
  - In HOLD: id_valid <= 0, go to IDLE, regardless of id_ready (redirect wins; pc_sel=1, no pc+4 increment).
- Redirect while kill is already set: kill stays 1. Only one response is outstanding, so a single flag suffices.
- Reset mid-fetch: all state cleared. The memory side is reset by the same rst, so no stale response arrives.
- pc[1:0] is ignored; alignment is checked downstream.

Decomposition:
- Shared macro/package holds state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3), the beat-align mask, and the INST_W/MEM_W constants.
- Single module; an optional sub-module ysyx_22041461_inst_sel (beat-to-word select) is the only natural split.

Test Plan:
- Reset then pc=0x80000000, memory ready immediately, rsp 1 cycle later with data 0x00100093_00000013, id_ready=1 -> id_inst=0x00000013, id_pc=0x80000000, pc_enable=1 with pc_sel=0 for exactly one cycle.
- pc=0x80000004, same data -> id_inst=0x00100093 (upper word selected).
- id_ready held low 5 cycles in HOLD -> id_valid/id_inst/id_pc stable, pc_enable=0 throughout, no new imem_req_valid.
- Redirect in WAIT, response arrives 3 cycles later -> response discarded, id_valid stays 0, next request uses the redirect-target pc.
- Redirect and id_ready in the same HOLD cycle -> pc_enable=1, pc_sel=1, id_valid drops, FSM goes to IDLE.
- rst asserted low while in WAIT -> outputs zero immediately; after release the first request is issued from IDLE->REQ.
